// File: rtl/main_fsm_pkg.sv
// Shared state encoding, datapath select encodings and instruction-field decode
// helpers for the multicycle ARMv4 main controller.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXER,
    EXEI,
    ALUWB,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    BRANCH,
    HALT
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WDATA  = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Extension format follows the instruction class; undefined class uses DP.
  function automatic logic [1:0] imm_src(input logic [1:0] op);
    case (op)
      OP_MEM:  imm_src = IMM_MEM;
      OP_BR:   imm_src = IMM_BR;
      default: imm_src = IMM_DP;
    endcase
  endfunction

  // {shift select, STR reads Rd, branch uses PC as Rn}
  function automatic logic [2:0] reg_src(input logic [1:0] op, input logic funct0,
                                         input logic [3:0] cmd);
    reg_src = {(op == OP_DP) && (cmd == CMD_MOV),
               (op == OP_MEM) && !funct0,
               (op == OP_BR)};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags the last cycle allowed before an abort.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  // The controller clears on every abort, so the count never passes LAST.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle ARMv4 main controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing with a
// ready handshake and wait timeout. Define ILLEGAL_TRAP_EN to trap Op=11 in HALT.
module multicycle_main_fsm
  import main_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          NOWB_CMP    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic       Funct5,
  input  logic       Funct0,
  input  logic [3:0] Cmd,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       Branch,
  output logic       RegW,
  output logic       MemW,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ImmSrc,
  output logic [2:0] RegSrc,
  output logic       MemErr,
  output logic       Illegal
);

  state_t state;
  state_t next_state;
  logic   waiting;
  logic   expired;
  logic   abort;
  logic   timer_clear;
  logic   skip_wb;

  assign waiting = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !MemReady;
  assign abort   = waiting && expired;
  assign skip_wb = NOWB_CMP && (Cmd[3:2] == 2'b10);

  // Re-arm on every state change and on abort so each new wait starts from zero.
  assign timer_clear = abort || (next_state != state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (waiting && !abort),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (MemReady) next_state = DECODE;
      end
      DECODE: begin
        case (Op)
          OP_DP:   next_state = Funct5 ? EXEI : EXER;
          OP_MEM:  next_state = MEMADR;
          OP_BR:   next_state = BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default: next_state = HALT;
`else
          default: next_state = FETCH;
`endif
        endcase
      end
      EXER, EXEI: next_state = skip_wb ? FETCH : ALUWB;
      ALUWB:      next_state = FETCH;
      MEMADR:     next_state = Funct0 ? MEMRD : MEMWR;
      MEMRD: begin
        if (MemReady)   next_state = MEMWB;
        else if (abort) next_state = FETCH;
      end
      MEMWB:      next_state = FETCH;
      MEMWR: begin
        if (MemReady || abort) next_state = FETCH;
      end
      BRANCH:     next_state = FETCH;
`ifdef ILLEGAL_TRAP_EN
      HALT:       next_state = HALT;
`endif
      default:    next_state = FETCH;
    endcase
  end

  // Outputs follow state and the live handshake; everything is held low in reset.
  always_comb begin
    MemReq    = 1'b0;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    Branch    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_WDATA;
    ALUOp     = 1'b0;
    ImmSrc    = imm_src(Op);
    RegSrc    = reg_src(Op, Funct0, Cmd);
    MemErr    = abort;
    Illegal   = 1'b0;
    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        IRWrite   = MemReady;
        NextPC    = MemReady;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      EXER: begin
        ALUSrcB = SRCB_WDATA;
        ALUOp   = 1'b1;
      end
      EXEI: begin
        ALUSrcB = SRCB_EXTIMM;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegW      = 1'b1;
      end
      MEMADR: begin
        ALUSrcB = SRCB_EXTIMM;
      end
      MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      HALT: begin
        Illegal = 1'b1;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      MemReq    = 1'b0;
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      Branch    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALUOp     = 1'b0;
      ImmSrc    = 2'b00;
      RegSrc    = 3'b000;
      MemErr    = 1'b0;
      Illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboarded bench for multicycle_main_fsm; expected output vectors per cycle
// are built from the state table and queued as each cycle's stimulus is driven.
module tb_multicycle_main_fsm;

  localparam int unsigned OW = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] op = 2'b00;
  logic       funct5 = 1'b0;
  logic       funct0 = 1'b0;
  logic [3:0] cmd = 4'b0000;
  logic       mem_ready = 1'b0;
  wire  [OW-1:0] obs;
  wire  [OW-1:0] obs_nb;

  logic [OW-1:0] sb[$];
  logic [OW-1:0] want;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.MEM_TIMEOUT(4), .NOWB_CMP(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(op), .Funct5(funct5), .Funct0(funct0), .Cmd(cmd),
    .MemReady(mem_ready), .MemReq(obs[19]), .IRWrite(obs[18]), .NextPC(obs[17]),
    .Branch(obs[16]), .RegW(obs[15]), .MemW(obs[14]), .AdrSrc(obs[13]),
    .ResultSrc(obs[12:11]), .ALUSrcA(obs[10]), .ALUSrcB(obs[9:8]), .ALUOp(obs[7]),
    .ImmSrc(obs[6:5]), .RegSrc(obs[4:2]), .MemErr(obs[1]), .Illegal(obs[0])
  );

  multicycle_main_fsm #(.MEM_TIMEOUT(4), .NOWB_CMP(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .Op(op), .Funct5(funct5), .Funct0(funct0), .Cmd(cmd),
    .MemReady(mem_ready), .MemReq(obs_nb[19]), .IRWrite(obs_nb[18]), .NextPC(obs_nb[17]),
    .Branch(obs_nb[16]), .RegW(obs_nb[15]), .MemW(obs_nb[14]), .AdrSrc(obs_nb[13]),
    .ResultSrc(obs_nb[12:11]), .ALUSrcA(obs_nb[10]), .ALUSrcB(obs_nb[9:8]),
    .ALUOp(obs_nb[7]), .ImmSrc(obs_nb[6:5]), .RegSrc(obs_nb[4:2]), .MemErr(obs_nb[1]),
    .Illegal(obs_nb[0])
  );

  // Expected vector: {MemReq,IRWrite,NextPC,Branch,RegW,MemW,AdrSrc,ResultSrc,
  // ALUSrcA,ALUSrcB,ALUOp,ImmSrc,RegSrc,MemErr,Illegal}
  function automatic logic [OW-1:0] ev(input logic mreq, input logic irw, input logic npc,
                                       input logic br, input logic rw, input logic mw,
                                       input logic adr, input logic [1:0] rs,
                                       input logic sa, input logic [1:0] sbs,
                                       input logic aop, input logic err, input logic ill);
    logic [1:0] imm;
    logic [2:0] rsrc;
    imm  = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
    rsrc = {(op == 2'b00) && (cmd == 4'b1101), (op == 2'b01) && !funct0, op == 2'b10};
    return {mreq, irw, npc, br, rw, mw, adr, rs, sa, sbs, aop, imm, rsrc, err, ill};
  endfunction

  function automatic logic [OW-1:0] f_zero();
    return '0;
  endfunction
  function automatic logic [OW-1:0] f_fetch(input logic r, input logic err);
    return ev(1'b1, r, r, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0, err, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_decode();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_exer();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_exei();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_aluwb();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_memadr();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_memrd();
    return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_memwb();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_memwr(input logic err);
    return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, err, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_branch();
    return ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [OW-1:0] f_halt();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic test_reset();
    logic [OW-1:0] e [10];
    logic rst [10];
    logic r [10];
    op = 2'b00; funct5 = 1'b0; funct0 = 1'b0; cmd = 4'b0000;
    e   = '{f_zero(), f_zero(), f_fetch(1'b0, 1'b0), f_fetch(1'b0, 1'b0), f_zero(),
            f_fetch(1'b0, 1'b0), f_fetch(1'b0, 1'b0), f_fetch(1'b0, 1'b0),
            f_fetch(1'b0, 1'b1), f_fetch(1'b0, 1'b0)};
    rst = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    r   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (e[i]) begin
      @(negedge clk);
      reset = rst[i]; mem_ready = r[i];
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_add();
    logic [OW-1:0] e [5];
    logic r [5];
    op = 2'b00; funct5 = 1'b0; funct0 = 1'b0; cmd = 4'b0100;
    e = '{f_fetch(1'b1, 1'b0), f_decode(), f_exer(), f_aluwb(), f_fetch(1'b0, 1'b0)};
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (e[i]) begin
      @(negedge clk);
      mem_ready = r[i];
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL add[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_exei_mov();
    logic [OW-1:0] e [5];
    logic r [5];
    op = 2'b00; funct5 = 1'b1; funct0 = 1'b0; cmd = 4'b1101;
    e = '{f_fetch(1'b1, 1'b0), f_decode(), f_exei(), f_aluwb(), f_fetch(1'b0, 1'b0)};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    foreach (e[i]) begin
      @(negedge clk);
      mem_ready = r[i];
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL exei_mov[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_cmp();
    logic [OW-1:0] e [5];
    logic [OW-1:0] e_nb [5];
    logic [OW-1:0] w_nb;
    logic r [5];
    op = 2'b00; funct5 = 1'b0; funct0 = 1'b1; cmd = 4'b1010;
    e    = '{f_fetch(1'b1, 1'b0), f_decode(), f_exer(), f_fetch(1'b0, 1'b0),
             f_fetch(1'b0, 1'b0)};
    e_nb = '{f_fetch(1'b1, 1'b0), f_decode(), f_exer(), f_aluwb(), f_fetch(1'b0, 1'b0)};
    r    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (e[i]) begin
      @(negedge clk);
      mem_ready = r[i];
      sb.push_back(e[i]);
      sb.push_back(e_nb[i]);
      #1;
      want = sb.pop_front();
      w_nb = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL cmp_nowb[%0d]: got %b want %b", i, obs, want);
      end
      vectors++;
      if (obs_nb !== w_nb) begin
        miscompares++;
        $display("FAIL cmp_wb[%0d]: got %b want %b", i, obs_nb, w_nb);
      end
    end
  endtask

  task automatic test_ldr_wait();
    logic [OW-1:0] e [9];
    logic r [9];
    op = 2'b01; funct5 = 1'b0; funct0 = 1'b1; cmd = 4'b1100;
    e = '{f_fetch(1'b1, 1'b0), f_decode(), f_memadr(), f_memrd(), f_memrd(), f_memrd(),
          f_memrd(), f_memwb(), f_fetch(1'b0, 1'b0)};
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    foreach (e[i]) begin
      @(negedge clk);
      mem_ready = r[i];
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL ldr_wait[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_str_timeout();
    logic [OW-1:0] e [8];
    op = 2'b01; funct5 = 1'b0; funct0 = 1'b0; cmd = 4'b1100;
    e = '{f_fetch(1'b1, 1'b0), f_decode(), f_memadr(), f_memwr(1'b0), f_memwr(1'b0),
          f_memwr(1'b0), f_memwr(1'b1), f_fetch(1'b0, 1'b0)};
    foreach (e[i]) begin
      @(negedge clk);
      mem_ready = (i == 0);
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL str_timeout[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_branch_fetch_timeout();
    logic [OW-1:0] e [8];
    op = 2'b10; funct5 = 1'b1; funct0 = 1'b0; cmd = 4'b0011;
    e = '{f_fetch(1'b1, 1'b0), f_decode(), f_branch(), f_fetch(1'b0, 1'b0),
          f_fetch(1'b0, 1'b0), f_fetch(1'b0, 1'b0), f_fetch(1'b0, 1'b1),
          f_fetch(1'b0, 1'b0)};
    foreach (e[i]) begin
      @(negedge clk);
      mem_ready = (i == 0);
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_mem_wait();
    logic [OW-1:0] e [12];
    logic rst [12];
    logic r [12];
    op = 2'b01; funct5 = 1'b0; funct0 = 1'b1; cmd = 4'b0000;
    e   = '{f_fetch(1'b1, 1'b0), f_decode(), f_memadr(), f_memrd(), f_memrd(), f_zero(),
            f_fetch(1'b1, 1'b0), f_decode(), f_memadr(), f_memrd(), f_memwb(),
            f_fetch(1'b0, 1'b0)};
    rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    r   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    foreach (e[i]) begin
      @(negedge clk);
      reset = rst[i]; mem_ready = r[i];
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL reset_mem[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

`ifdef ILLEGAL_TRAP_EN
  task automatic test_op11();
    logic [OW-1:0] e [7];
    logic rst [7];
    logic r [7];
    op = 2'b11; funct5 = 1'b0; funct0 = 1'b0; cmd = 4'b0000;
    e   = '{f_fetch(1'b1, 1'b0), f_decode(), f_halt(), f_halt(), f_halt(), f_zero(),
            f_fetch(1'b0, 1'b0)};
    rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    r   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    foreach (e[i]) begin
      @(negedge clk);
      reset = rst[i]; mem_ready = r[i];
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL op11_halt[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask
`else
  task automatic test_op11();
    logic [OW-1:0] e [4];
    logic r [4];
    op = 2'b11; funct5 = 1'b0; funct0 = 1'b0; cmd = 4'b0000;
    e = '{f_fetch(1'b1, 1'b0), f_decode(), f_fetch(1'b0, 1'b0), f_fetch(1'b0, 1'b0)};
    r = '{1'b1, 1'b0, 1'b0, 1'b0};
    foreach (e[i]) begin
      @(negedge clk);
      mem_ready = r[i];
      sb.push_back(e[i]);
      #1;
      want = sb.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL op11_nop[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_exei_mov();
    test_cmp();
    test_ldr_wait();
    test_str_timeout();
    test_branch_fetch_timeout();
    test_reset_mem_wait();
    test_op11();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
